uart_mem_ctrl: RTL and testbench
================================

# uart_mem_ctrl

Sequencing controller for the UART loopback memory path. Sits between the byte-level UART receiver, the UART transmitter and a synchronous byte RAM. In receive mode it writes each received byte into consecutive RAM locations. When the `mem2uart` switch selects transmit mode, it reads the stored bytes back in order and feeds them to the transmitter one at a time, reporting completion on `recv_done` / `send_done` (board LEDs).

## Interface
- `DEPTH`, 16: number of RAM byte locations, power of two.
- `ADDR_W`, 4: RAM address width, equal to log2(`DEPTH`).
- `clk`  in  1: system clock, 100 MHz.
- `rst`  in  1: reset, asynchronous and active-high (BTNU).
- `mem2uart`  in  1: mode level; 0 = receive into RAM, 1 = transmit from RAM (SW0).
- `rx_valid`  in  1: one-cycle pulse from receiver; `rx_byte` valid.
- `rx_byte`  in  8: received byte.
- `tx_start`  out  1: one-cycle pulse; transmitter begins a frame with `tx_byte`.
- `tx_byte`  out  8: byte to send; held stable from `tx_start` until `tx_done`.
- `tx_done`  in  1: one-cycle pulse from transmitter at end of stop bit.
- `mem_we`  out  1: RAM write enable.
- `mem_addr`  out  ADDR_W: RAM address.
- `mem_wdata`  out  8: RAM write data.
- `mem_rdata`  in  8: RAM read data; synchronous read, valid one cycle after `mem_addr`.
- `recv_done`  out  1: sticky; RAM holds `DEPTH` bytes.
- `send_done`  out  1: sticky; all stored bytes transmitted.
- `overrun`  out  1: sticky; an `rx_valid` was dropped.

## Operation
- Registers: `wr_ptr` (ADDR_W+1 bits, byte count), `rd_ptr` (ADDR_W bits), state.
- States: RECV, RD, LATCH, START, WAIT, DONE. Reset state is RECV.
- RECV:
  - `rx_valid` with `wr_ptr < DEPTH`: `mem_we`=1, `mem_addr`=`wr_ptr`, `mem_wdata`=`rx_byte` in the same cycle; `wr_ptr` increments.
  - When `wr_ptr` reaches `DEPTH`, `recv_done`=1.
  - `rx_valid` with `wr_ptr == DEPTH`: byte dropped, `overrun`=1.
- RECV with `mem2uart`=1:
  - `wr_ptr`=0: go to DONE directly. No `tx_start` is issued.
  - Otherwise: `rd_ptr`=0, go to RD.
- RD: `mem_addr`=`rd_ptr`, then go to LATCH.
- LATCH: `tx_byte` <= `mem_rdata`, then go to START.
- START: `tx_start`=1 for exactly one cycle, then go to WAIT.
- WAIT: hold until `tx_done`.
  - If `rd_ptr` == `wr_ptr`-1: go to DONE.
  - Otherwise: `rd_ptr` increments, go to RD.
- DONE: `send_done`=1.
- Falling `mem2uart`:
  - Any state other than RECV: clear `wr_ptr`, `rd_ptr`, `recv_done`, `send_done` and `overrun`, then go to RECV, starting a new session.
  - Mid-frame (in WAIT): the transmitter finishes its current frame; its `tx_done` is ignored.
- `rx_valid` outside RECV: dropped, sets `overrun`.
- `rx_valid` and rising `mem2uart` in the same RECV cycle: the byte is written first, then the transition to RD happens with the updated count.
- `mem2uart` already 1 when leaving reset: the controller goes to DONE on the next edge, because `wr_ptr`=0.

## Timing
- Reset values: all outputs 0, `wr_ptr`=0, `rd_ptr`=0, state RECV. `rst` takes effect immediately, independent of `clk`.
- `rx_valid` at edge N: RAM write at edge N (combinational `mem_we`); `recv_done` rises after edge N for the `DEPTH`th byte.
- `mem2uart`=1 sampled at edge N in RECV: RD during N..N+1, LATCH during N+1..N+2, `tx_start` high during N+2..N+3.
- `tx_done` at edge M: next `tx_start` high during M+2..M+3, a 3-cycle gap. `send_done` rises after edge M for the last byte.
- No combinational path from `tx_done` or `mem2uart` to any output. `mem_*` write outputs are combinational from `rx_valid`/`rx_byte` in RECV only.

## Structure
- Shared package `uart_mem_pkg` holds:
  - the state enum;
  - `BYTE_W`=8;
  - `DEFAULT_DEPTH`=16;
  - `CLKS_PER_BIT`=10417 (9600 baud at 100 MHz), used by the UART sub-blocks and benches.
- No sub-module: one FSM plus two counters. The RAM, receiver and transmitter are instantiated by the top level, not inside this block.

## Test plan
- Reset, then 16 `rx_valid` pulses with bytes 0x01,0x02,0x03,0x04,0x04,0x03,0x02,0x01,0x00..0x07 -> RAM addresses 0..15 hold those bytes; `recv_done`=1 after the 16th pulse; `overrun`=0.
- Then `mem2uart`=1 with a transmitter model returning `tx_done` 100 cycles after each `tx_start` -> 16 `tx_start` pulses with `tx_byte` in the same order; first pulse 2 cycles after the sampling edge; `send_done`=1 after the 16th `tx_done`.
- 5 bytes received, then `mem2uart`=1 -> exactly 5 frames; `recv_done`=0; `send_done`=1.
- 17th `rx_valid` after full -> `overrun`=1; RAM address 0 unchanged; `wr_ptr`=16.
- `rst` pulse during WAIT of byte 7 -> all outputs 0 immediately; a later `tx_done` is ignored; state RECV.
- `mem2uart`=1 with 0 bytes received -> `send_done`=1 within 2 cycles, no `tx_start`; `mem2uart`=0 -> `send_done` clears, receive session restarts at address 0.

Source files
------------

// File: rtl/uart_mem_pkg.sv
// Shared types and constants for the UART loopback memory path.
package uart_mem_pkg;

  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned DEFAULT_DEPTH = 16;
  // 9600 baud at 100 MHz
  localparam int unsigned CLKS_PER_BIT  = 10417;

  typedef enum logic [2:0] {
    StRecv,
    StRd,
    StLatch,
    StStart,
    StWait,
    StDone
  } ctrl_state_e;

endpackage

// File: rtl/uart_mem_ctrl_if.sv
// Receiver, transmitter and RAM handshake signals around the memory controller.
interface uart_mem_ctrl_if #(
  parameter int unsigned ADDR_W = 4
);
  import uart_mem_pkg::*;

  logic              rx_valid;
  logic [BYTE_W-1:0] rx_byte;
  logic              tx_start;
  logic [BYTE_W-1:0] tx_byte;
  logic              tx_done;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [BYTE_W-1:0] mem_wdata;
  logic [BYTE_W-1:0] mem_rdata;

  modport master (
    input  rx_valid, rx_byte, tx_done, mem_rdata,
    output tx_start, tx_byte, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_valid, rx_byte, tx_done, mem_rdata,
    input  tx_start, tx_byte, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/uart_mem_ctrl.sv
// Sequencer: stores received bytes into RAM, then replays them to the transmitter
// in order when mem2uart selects transmit mode.
module uart_mem_ctrl
  import uart_mem_pkg::*;
#(
  parameter int unsigned DEPTH  = DEFAULT_DEPTH,
  parameter int unsigned ADDR_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem2uart,
  uart_mem_ctrl_if.master bus,
  output logic            recv_done,
  output logic            send_done,
  output logic            overrun
);

  localparam logic [ADDR_W:0] Full = (ADDR_W + 1)'(DEPTH);

  ctrl_state_e       state_q, state_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [BYTE_W-1:0] tx_byte_q, tx_byte_d;
  logic              recv_done_q, recv_done_d;
  logic              overrun_q, overrun_d;
  logic              wr_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StRecv;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      tx_byte_q   <= '0;
      recv_done_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      tx_byte_q   <= tx_byte_d;
      recv_done_q <= recv_done_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    tx_byte_d   = tx_byte_q;
    recv_done_d = recv_done_q;
    overrun_d   = overrun_q;

    wr_ok = (state_q == StRecv) && bus.rx_valid && (wr_ptr_q != Full);
    if (wr_ok) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (wr_ptr_d == Full) recv_done_d = 1'b1;
    end else if (bus.rx_valid) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      StRecv: begin
        // Mode decision uses the count including a byte written this same cycle
        if (mem2uart) begin
          if (wr_ptr_d == '0) begin
            state_d = StDone;
          end else begin
            rd_ptr_d = '0;
            state_d  = StRd;
          end
        end
      end
      StRd:    state_d = StLatch;
      StLatch: begin
        tx_byte_d = bus.mem_rdata;
        state_d   = StStart;
      end
      StStart: state_d = StWait;
      StWait: begin
        if (bus.tx_done) begin
          if ({1'b0, rd_ptr_q} == wr_ptr_q - 1'b1) begin
            state_d = StDone;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            state_d  = StRd;
          end
        end
      end
      StDone:  state_d = StDone;
      default: state_d = StRecv;
    endcase

    // Leaving transmit mode aborts the session; an in-flight frame's tx_done is then ignored
    if ((state_q != StRecv) && !mem2uart) begin
      state_d     = StRecv;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      recv_done_d = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  assign bus.mem_we    = wr_ok;
  assign bus.mem_wdata = wr_ok ? bus.rx_byte : '0;
  assign bus.mem_addr  = (state_q == StRecv) ? wr_ptr_q[ADDR_W-1:0] : rd_ptr_q;
  assign bus.tx_start  = (state_q == StStart);
  assign bus.tx_byte   = tx_byte_q;
  assign recv_done     = recv_done_q;
  assign send_done     = (state_q == StDone);
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_uart_mem_ctrl.sv
// Bench for uart_mem_ctrl: RAM and transmitter models, byte-queue reference of the session.
module tb_uart_mem_ctrl;
  import uart_mem_pkg::*;

  localparam int unsigned DEPTH  = DEFAULT_DEPTH;
  localparam int unsigned ADDR_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic mem2uart;
  logic recv_done, send_done, overrun;

  uart_mem_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  uart_mem_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem2uart  (mem2uart),
    .bus       (bus),
    .recv_done (recv_done),
    .send_done (send_done),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;
  longint unsigned cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    vectors++;
    if (obs !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, want);
    end
  endtask

  // Synchronous byte RAM
  logic [7:0] ram [DEPTH];
  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  // Transmitter model: tx_done 100 cycles after each tx_start
  logic [7:0]      start_bytes [$];
  longint unsigned start_edges [$];
  longint unsigned done_edges  [$];
  int unsigned     tx_cnt = 0;
  logic [7:0]      held = '0;
  logic            chk_hold = 1'b1;

  always @(posedge clk) begin
    bus.tx_done <= 1'b0;
    if (tx_cnt != 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) begin
        bus.tx_done <= 1'b1;
        done_edges.push_back(cyc + 1);
        if (chk_hold) check("tx_byte_hold", 32'(bus.tx_byte), 32'(held));
      end
    end
    if (bus.tx_start) begin
      start_bytes.push_back(bus.tx_byte);
      start_edges.push_back(cyc);
      held   <= bus.tx_byte;
      tx_cnt <= 100;
    end
  end

  // Reference model: bytes accepted this session, in order
  logic [7:0]      exp_q [$];
  logic            m_ov   = 1'b0;
  logic            m_recv = 1'b1;
  longint unsigned n_edge = 0;

  logic [7:0] pat [16] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h04, 8'h03, 8'h02, 8'h01,
                           8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_tx_log();
    start_bytes.delete();
    start_edges.delete();
    done_edges.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tx_start"},  32'(bus.tx_start),  32'd0);
    check({tag, "_tx_byte"},   32'(bus.tx_byte),   32'd0);
    check({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
    check({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
    check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    check({tag, "_recv_done"}, 32'(recv_done),     32'd0);
    check({tag, "_send_done"}, 32'(send_done),     32'd0);
    check({tag, "_overrun"},   32'(overrun),       32'd0);
  endtask

  task automatic rx_send(input logic [7:0] b, input bit with_mode);
    logic exp_we;
    exp_we = m_recv && (exp_q.size() < DEPTH);
    bus.rx_valid = 1'b1;
    bus.rx_byte  = b;
    if (with_mode) mem2uart = 1'b1;
    #1;
    check("mem_we", 32'(bus.mem_we), 32'(exp_we));
    if (exp_we) begin
      check("mem_addr",  32'(bus.mem_addr),  32'(exp_q.size()));
      check("mem_wdata", 32'(bus.mem_wdata), 32'(b));
      exp_q.push_back(b);
    end else begin
      m_ov = 1'b1;
    end
    step();
    bus.rx_valid = 1'b0;
    if (with_mode) begin
      n_edge = cyc - 1;
      m_recv = 1'b0;
      clear_tx_log();
    end
    check("recv_done", 32'(recv_done), 32'(exp_q.size() == DEPTH));
    check("overrun",   32'(overrun),   32'(m_ov));
  endtask

  task automatic start_tx();
    mem2uart = 1'b1;
    step();
    n_edge = cyc - 1;
    m_recv = 1'b0;
    clear_tx_log();
  endtask

  task automatic finish_tx(input int budget);
    int k;
    int n;
    n = exp_q.size();
    k = 0;
    while (!send_done && k < budget) begin
      step();
      k++;
    end
    check("send_done", 32'(send_done), 32'd1);
    check("frames", 32'(start_bytes.size()), 32'(n));
    for (int i = 0; i < n && i < start_bytes.size(); i++)
      check("tx_byte", 32'(start_bytes[i]), 32'(exp_q[i]));
    if (start_edges.size() > 0) check("first_start", 32'(start_edges[0] - n_edge), 32'd3);
    for (int i = 1; i < start_edges.size() && i <= done_edges.size(); i++)
      check("start_gap", 32'(start_edges[i] - done_edges[i-1]), 32'd3);
    if (n > 0 && done_edges.size() > 0)
      check("done_edge", 32'(cyc - 1), 32'(done_edges[done_edges.size()-1]));
    check("tx_recv_done", 32'(recv_done), 32'(exp_q.size() == DEPTH));
    check("tx_overrun",   32'(overrun),   32'(m_ov));
    for (int i = 0; i < exp_q.size(); i++) check("ram", 32'(ram[i]), 32'(exp_q[i]));
  endtask

  task automatic end_session();
    mem2uart = 1'b0;
    step();
    check("end_send_done", 32'(send_done), 32'd0);
    check("end_recv_done", 32'(recv_done), 32'd0);
    check("end_overrun",   32'(overrun),   32'd0);
    exp_q.delete();
    m_ov   = 1'b0;
    m_recv = 1'b1;
  endtask

  initial begin
    int unsigned cnt;
    int unsigned gap;
    bit          coinc;
    int          k;

    rst          = 1'b1;
    mem2uart     = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_byte  = '0;
    #3;
    check_zero("reset");
    step();
    step();
    rst = 1'b0;

    // Empty session: straight to DONE, no frames
    start_tx();
    finish_tx(2);
    end_session();

    // Directed fill, then one byte past full
    for (int i = 0; i < 16; i++) rx_send(pat[i], 1'b0);
    for (int i = 0; i < 16; i++) check("ram_fill", 32'(ram[i]), 32'(pat[i]));
    rx_send(8'hAA, 1'b0);
    check("ram0_kept", 32'(ram[0]), 32'h01);
    start_tx();
    finish_tx(16 * 110 + 10);
    end_session();

    // Partial session of 5 bytes
    for (int i = 0; i < 5; i++) rx_send(8'(8'h30 + i), 1'b0);
    start_tx();
    finish_tx(5 * 110 + 10);
    end_session();

    // Randomized sessions
    for (int s = 0; s < 6; s++) begin
      cnt   = $urandom_range(0, 18);
      coinc = ($urandom_range(0, 1) == 1) && (cnt > 0);
      for (int i = 0; i < int'(cnt); i++) begin
        gap = $urandom_range(0, 3);
        repeat (gap) step();
        rx_send(8'($urandom), coinc && (i == int'(cnt) - 1));
      end
      if (!coinc) start_tx();
      finish_tx(int'(cnt) * 110 + 10);
      if ($urandom_range(0, 1) == 1) rx_send(8'($urandom), 1'b0);
      end_session();
    end

    // Reset while waiting on the 7th frame
    for (int i = 0; i < 16; i++) rx_send(8'($urandom), 1'b0);
    start_tx();
    k = 0;
    while (start_bytes.size() < 7 && k < 1000) begin
      step();
      k++;
    end
    check("reach_frame7", 32'(start_bytes.size()), 32'd7);
    chk_hold = 1'b0;
    repeat (5) step();
    #2;
    rst      = 1'b1;
    mem2uart = 1'b0;
    #1;
    check_zero("mid_rst");
    step();
    rst = 1'b0;
    repeat (110) step();
    check("no_start_after_rst", 32'(start_bytes.size()), 32'd7);
    check("rst_send_done", 32'(send_done), 32'd0);
    chk_hold = 1'b1;
    exp_q.delete();
    m_ov   = 1'b0;
    m_recv = 1'b1;
    rx_send(8'h5A, 1'b0);

    // Leaving reset with mem2uart already high
    rst      = 1'b1;
    mem2uart = 1'b1;
    #1;
    check("rst_hi_send_done", 32'(send_done), 32'd0);
    step();
    rst = 1'b0;
    clear_tx_log();
    step();
    check("rst_hi_done", 32'(send_done), 32'd1);
    repeat (3) step();
    check("rst_hi_no_start", 32'(start_bytes.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
